// File: rtl/digital_clock_pkg.sv
// Shared definitions for the digital clock: clock rate, beeper state encodings
// and the default tone/cadence timing derived from the clock rate.
package digital_clock_pkg;

    localparam int unsigned CLK_HZ  = 100_000_000;
    localparam int unsigned TONE_HZ = 2_000;

    localparam int unsigned DEF_TONE_HALF = CLK_HZ / (2 * TONE_HZ);
    localparam int unsigned DEF_BEEP_HALF = CLK_HZ / 2;

    typedef enum logic [1:0] {
        BEEP_IDLE   = 2'd0,
        BEEP_RING   = 2'd1,
        BEEP_SNOOZE = 2'd2,
        BEEP_MUTED  = 2'd3
    } beep_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alarm_beeper_tone_div.sv
// Half-period divider: q toggles every HALF enabled cycles; clr restarts the
// count with q high so every burst begins on a high phase.
module tone_div
    import digital_clock_pkg::*;
#(
    parameter int unsigned HALF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic q
);

    localparam int unsigned W = cnt_width(HALF);
    localparam logic [W-1:0] LAST = W'(HALF - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            q   <= 1'b1;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
                q   <= ~q;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alarm_beeper.sv
// Alarm output stage: gated piezo tone with on/off cadence, blinking LED,
// limited snooze and auto-mute after a ring timeout.
module alarm_beeper
    import digital_clock_pkg::*;
#(
    parameter int unsigned TONE_HALF    = DEF_TONE_HALF,
    parameter int unsigned BEEP_HALF    = DEF_BEEP_HALF,
    parameter int unsigned RING_MAX_SEC = 60,
    parameter int unsigned SNOOZE_SEC   = 300,
    parameter int unsigned MAX_SNOOZE   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       alarm_on,
    input  logic       snooze,
    output logic       buzzer,
    output logic       alarm_led,
    output logic [1:0] state_o,
    output logic [1:0] snooze_left
);

    localparam int unsigned RW = cnt_width(RING_MAX_SEC);
    localparam int unsigned ZW = cnt_width(SNOOZE_SEC);
    localparam int unsigned CW = cnt_width(MAX_SNOOZE + 1);

    localparam logic [RW-1:0] RING_LAST = RW'(RING_MAX_SEC - 1);
    localparam logic [ZW-1:0] SNZ_LAST  = ZW'(SNOOZE_SEC - 1);
    localparam logic [CW-1:0] SNZ_MAX   = CW'(MAX_SNOOZE);

    beep_state_t state, next_state;

    logic [RW-1:0] ring_sec;
    logic [ZW-1:0] snz_sec;
    logic [CW-1:0] snooze_cnt;
    logic          tone_q, cad_on;
    logic          ring_entry, ring_run;

    always_ff @(posedge clk) begin
        if (rst) state <= BEEP_IDLE;
        else     state <= next_state;
    end

    // alarm_on dropping wins over everything; in RING snooze wins over timeout.
    always_comb begin
        next_state = state;
        unique case (state)
            BEEP_IDLE: begin
                if (alarm_on) next_state = BEEP_RING;
            end
            BEEP_RING: begin
                if (!alarm_on)                              next_state = BEEP_IDLE;
                else if (snooze && snooze_cnt < SNZ_MAX)    next_state = BEEP_SNOOZE;
                else if (sec_tick && ring_sec == RING_LAST) next_state = BEEP_MUTED;
            end
            BEEP_SNOOZE: begin
                if (!alarm_on)                             next_state = BEEP_IDLE;
                else if (sec_tick && snz_sec == SNZ_LAST)  next_state = BEEP_RING;
            end
            BEEP_MUTED: begin
                if (!alarm_on) next_state = BEEP_IDLE;
            end
            default: next_state = BEEP_IDLE;
        endcase
    end

    assign ring_entry = (state != BEEP_RING) && (next_state == BEEP_RING);
    assign ring_run   = (state == BEEP_RING);

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_sec   <= '0;
            snz_sec    <= '0;
            snooze_cnt <= '0;
        end else begin
            unique case (state)
                BEEP_IDLE: begin
                    ring_sec   <= '0;
                    snz_sec    <= '0;
                    snooze_cnt <= '0;
                end
                BEEP_RING: begin
                    if (next_state == BEEP_SNOOZE) begin
                        snooze_cnt <= snooze_cnt + 1'b1;
                        ring_sec   <= '0;
                        snz_sec    <= '0;
                    end else if (sec_tick && next_state == BEEP_RING) begin
                        ring_sec <= ring_sec + 1'b1;
                    end
                end
                BEEP_SNOOZE: begin
                    if (next_state == BEEP_RING) begin
                        ring_sec <= '0;
                        snz_sec  <= '0;
                    end else if (sec_tick && next_state == BEEP_SNOOZE) begin
                        snz_sec <= snz_sec + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    tone_div #(.HALF(TONE_HALF)) u_tone (
        .clk (clk),
        .rst (rst),
        .clr (ring_entry),
        .en  (ring_run),
        .q   (tone_q)
    );

    tone_div #(.HALF(BEEP_HALF)) u_cadence (
        .clk (clk),
        .rst (rst),
        .clr (ring_entry),
        .en  (ring_run),
        .q   (cad_on)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            buzzer    <= 1'b0;
            alarm_led <= 1'b0;
        end else begin
            buzzer    <= tone_q & cad_on & (state == BEEP_RING);
            alarm_led <= (state == BEEP_RING) ? cad_on : (state == BEEP_SNOOZE);
        end
    end

    assign state_o     = state;
    assign snooze_left = 2'(SNZ_MAX - snooze_cnt);

endmodule

// File: tb/tb_alarm_beeper.sv
// Directed and randomized checks of alarm_beeper against a cycle-level
// reference model built from the ring/snooze/mute rules.
module tb_alarm_beeper;

    localparam int TH  = 5;
    localparam int BH  = 20;
    localparam int RMX = 4;
    localparam int SMX = 3;
    localparam int MXS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sec_tick = 1'b0;
    logic       alarm_on = 1'b0;
    logic       snooze = 1'b0;
    logic       buzzer;
    logic       alarm_led;
    logic [1:0] state_o;
    logic [1:0] snooze_left;

    int checks   = 0;
    int failures = 0;

    // reference model: mode 0 idle, 1 ring, 2 snooze, 3 muted; age = cycles since ring entry
    int m_mode = 0, m_snz = 0, m_rsec = 0, m_zsec = 0, m_age = 0;
    int e_buz = 0, e_led = 0;

    alarm_beeper #(
        .TONE_HALF    (TH),
        .BEEP_HALF    (BH),
        .RING_MAX_SEC (RMX),
        .SNOOZE_SEC   (SMX),
        .MAX_SNOOZE   (MXS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sec_tick    (sec_tick),
        .alarm_on    (alarm_on),
        .snooze      (snooze),
        .buzzer      (buzzer),
        .alarm_led   (alarm_led),
        .state_o     (state_o),
        .snooze_left (snooze_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit a, input bit t, input bit s);
        int nxt;
        if (r) begin
            e_buz = 0; e_led = 0;
            m_mode = 0; m_snz = 0; m_rsec = 0; m_zsec = 0; m_age = 0;
            return;
        end
        e_buz = (m_mode == 1 && ((m_age / TH) % 2 == 0) && ((m_age / BH) % 2 == 0)) ? 1 : 0;
        e_led = (m_mode == 1) ? (((m_age / BH) % 2 == 0) ? 1 : 0) : ((m_mode == 2) ? 1 : 0);
        nxt = m_mode;
        case (m_mode)
            0: begin
                m_snz = 0; m_rsec = 0; m_zsec = 0;
                if (a) begin nxt = 1; m_age = 0; end
            end
            1: begin
                if (!a) nxt = 0;
                else if (s && m_snz < MXS) begin
                    nxt = 2; m_snz++; m_rsec = 0; m_zsec = 0;
                end else if (t) begin
                    if (m_rsec == RMX - 1) nxt = 3;
                    else m_rsec++;
                end
                if (nxt == 1) m_age++;
            end
            2: begin
                if (!a) nxt = 0;
                else if (t) begin
                    if (m_zsec == SMX - 1) begin nxt = 1; m_age = 0; m_rsec = 0; end
                    else m_zsec++;
                end
            end
            default: if (!a) nxt = 0;
        endcase
        m_mode = nxt;
    endtask

    task automatic step(input bit r, input bit a, input bit t, input bit s);
        rst = r; alarm_on = a; sec_tick = t; snooze = s;
        @(posedge clk);
        model(r, a, t, s);
        #1;
        chk("state", 32'(state_o), 32'(m_mode));
        chk("snooze_left", 32'(snooze_left), 32'(MXS - m_snz));
        chk("buzzer", 32'(buzzer), 32'(e_buz));
        chk("alarm_led", 32'(alarm_led), 32'(e_led));
    endtask

    initial begin
        bit ra, rt, rs, rr;

        // reset values
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_snooze_left", 32'(snooze_left), 32'd2);
        chk("rst_buzzer", 32'(buzzer), 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // ring start, tone and cadence
        step(0, 1, 0, 0);
        chk("ring_state", 32'(state_o), 32'd1);
        chk("ring_buz_lag", 32'(buzzer), 32'd0);
        step(0, 1, 0, 0);
        chk("ring_buz_on", 32'(buzzer), 32'd1);
        chk("ring_led_on", 32'(alarm_led), 32'd1);
        repeat (43) step(0, 1, 0, 0);

        // timeout to MUTED
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 0);
            step(0, 1, 0, 0);
        end
        chk("muted_state", 32'(state_o), 32'd3);
        chk("muted_buzzer", 32'(buzzer), 32'd0);
        repeat (5) step(0, 1, 0, 0);
        chk("muted_hold", 32'(state_o), 32'd3);
        step(0, 0, 0, 0);
        chk("muted_clear", 32'(state_o), 32'd0);

        // snooze sequence
        step(0, 1, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        chk("snz1_state", 32'(state_o), 32'd2);
        chk("snz1_left", 32'(snooze_left), 32'd1);
        step(0, 1, 0, 0);
        chk("snz1_led", 32'(alarm_led), 32'd1);
        repeat (3) step(0, 1, 1, 0);
        chk("snz1_back", 32'(state_o), 32'd1);
        step(0, 1, 0, 0);
        chk("snz1_rering_buz", 32'(buzzer), 32'd1);
        repeat (2) step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        chk("snz2_left", 32'(snooze_left), 32'd0);
        repeat (3) step(0, 1, 1, 0);
        repeat (2) step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        chk("snz3_ignored", 32'(state_o), 32'd1);

        // snooze and final tick together; then alarm drop on the same cycle
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (3) step(0, 1, 1, 0);
        step(0, 1, 1, 1);
        chk("simul_snooze", 32'(state_o), 32'd2);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (3) step(0, 1, 1, 0);
        step(0, 0, 1, 1);
        chk("simul_drop", 32'(state_o), 32'd0);

        // reset mid-snooze
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("midrst_state", 32'(state_o), 32'd0);
        chk("midrst_left", 32'(snooze_left), 32'd2);
        chk("midrst_led", 32'(alarm_led), 32'd0);

        // clear during snooze, then fresh ring
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("clr_state", 32'(state_o), 32'd0);
        step(0, 0, 0, 0);
        chk("clr_led", 32'(alarm_led), 32'd0);
        step(0, 1, 0, 0);
        chk("fresh_state", 32'(state_o), 32'd1);
        chk("fresh_left", 32'(snooze_left), 32'd2);

        // randomized traffic
        ra = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) ra = ~ra;
            rt = ($urandom_range(5) == 0);
            rs = ($urandom_range(24) == 0);
            rr = ($urandom_range(599) == 0);
            step(rr, ra, rt, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
